// File: rtl/muller_c_seq.sv
// rtl/muller_c_seq.sv - four-phase sequencer sharing one Muller C-element; optional watchdog via MULLER_C_TIMEOUT_EN
module muller_c_seq #(
  parameter int N_REQ          = 4,
  parameter int SKEW           = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             err,
  output logic             busy,
  output logic             c_a,
  output logic             c_b,
  input  logic             c_in
);

  localparam int IW = $clog2(N_REQ);
  localparam int SW = $clog2(SKEW + 1);
  localparam logic [SW-1:0]    SKEW_LAST = SW'(SKEW - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0  = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_RISE_A,
    S_WAIT_HI,
    S_FALL_A,
    S_WAIT_LO,
    S_DONE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   c_s;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          gidx;
  logic [IW-1:0]          pick_idx;
  logic [IW-1:0]          next_ptr;
  logic                   pick_valid;
  logic [SW-1:0]          skew_cnt;
  logic                   hold_err;

  if (SKEW < SYNC_STAGES + 1 || N_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("muller_c_seq: illegal parameter combination");
  end

`ifdef MULLER_C_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;
  logic          timeout;
  assign timeout = (to_cnt == TO_LAST);
`endif

  // modular increment of a requester index (wraps at N_REQ, not at 2**IW)
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int offs);
    int s;
    s = int'(base) + offs;
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  assign c_s      = sync[SYNC_STAGES-1];
  assign busy     = (state != S_IDLE);
  assign next_ptr = wrap_add(gidx, 1);

  // round-robin pick: scan downwards so the smallest offset from rr_ptr wins
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = rr_ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[wrap_add(rr_ptr, i)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_add(rr_ptr, i);
      end
    end
  end

  // synchroniser for the asynchronous C-element output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], c_in};
  end

  // handshake sequencer: arbitration, skewed a/b edges, hold checks, completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      c_a      <= 1'b0;
      c_b      <= 1'b0;
      rr_ptr   <= '0;
      gidx     <= '0;
      skew_cnt <= '0;
      hold_err <= 1'b0;
`ifdef MULLER_C_TIMEOUT_EN
      to_cnt   <= '0;
`endif
    end else begin
      done <= '0;
      err  <= 1'b0;
`ifdef MULLER_C_TIMEOUT_EN
      to_cnt <= (state == S_WAIT_HI || state == S_WAIT_LO) ? to_cnt + TW'(1) : '0;
`endif
      case (state)
        S_IDLE: begin
          if (|req) state <= S_ARB;
        end
        S_ARB: begin
          if (pick_valid) begin
            gidx     <= pick_idx;
            gnt      <= ONE_HOT0 << pick_idx;
            c_a      <= 1'b1;
            skew_cnt <= '0;
            hold_err <= 1'b0;
            state    <= S_RISE_A;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RISE_A: begin
          if (skew_cnt == SKEW_LAST) begin
            skew_cnt <= '0;
            // c must not rise while only a is high
            if (c_s) begin
              err      <= 1'b1;
              c_a      <= 1'b0;
              c_b      <= 1'b0;
              hold_err <= 1'b1;
              state    <= S_WAIT_LO;
            end else begin
              c_b   <= 1'b1;
              state <= S_WAIT_HI;
            end
          end else begin
            skew_cnt <= skew_cnt + SW'(1);
          end
        end
        S_WAIT_HI: begin
`ifdef MULLER_C_TIMEOUT_EN
          if (timeout) begin
            err    <= 1'b1;
            c_a    <= 1'b0;
            c_b    <= 1'b0;
            gnt    <= '0;
            rr_ptr <= next_ptr;
            state  <= S_IDLE;
          end else
`endif
          if (c_s) begin
            c_a      <= 1'b0;
            skew_cnt <= '0;
            state    <= S_FALL_A;
          end
        end
        S_FALL_A: begin
          if (skew_cnt == SKEW_LAST) begin
            skew_cnt <= '0;
            // c must not fall while only a is low
            if (!c_s) begin
              err      <= 1'b1;
              c_b      <= 1'b0;
              hold_err <= 1'b1;
              state    <= S_WAIT_LO;
            end else begin
              c_b   <= 1'b0;
              state <= S_WAIT_LO;
            end
          end else begin
            skew_cnt <= skew_cnt + SW'(1);
          end
        end
        S_WAIT_LO: begin
`ifdef MULLER_C_TIMEOUT_EN
          if (timeout) begin
            err    <= 1'b1;
            c_a    <= 1'b0;
            c_b    <= 1'b0;
            gnt    <= '0;
            rr_ptr <= next_ptr;
            state  <= S_IDLE;
          end else
`endif
          if (!c_s) begin
            if (hold_err) begin
              gnt    <= '0;
              rr_ptr <= next_ptr;
              state  <= S_IDLE;
            end else begin
              done  <= gnt;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          gnt    <= '0;
          rr_ptr <= next_ptr;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muller_c_seq.sv
// tb/tb_muller_c_seq.sv - self-checking bench for muller_c_seq with a transaction-timeline model
module tb_muller_c_seq;

  localparam int N = 4;
  localparam int K = 4;
  localparam int S = 2;
  localparam int T = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [N-1:0] done;
  logic         err;
  logic         busy;
  logic         c_a;
  logic         c_b;
  logic         c_in = 1'b0;
  logic [1:0]   mode;

  int cyc      = 0;
  int nchk     = 0;
  int nerr     = 0;
  int done_cnt = 0;

  // model: mk is the offset within the current transaction (0 = idle cycle)
  int mk    = 0;
  int mwin  = 0;
  int mptr  = 0;
  int mmode = 0;
  bit merr  = 1'b0;

  muller_c_seq #(
    .N_REQ(N), .SKEW(K), .SYNC_STAGES(S), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .done(done), .err(err),
    .busy(busy), .c_a(c_a), .c_b(c_b), .c_in(c_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // C-element stand-in: 0 ideal, 1 follows a alone, 2 stuck at 0
  always @(c_a, c_b, mode) begin
    case (mode)
      2'd1:    c_in = c_a;
      2'd2:    c_in = 1'b0;
      default: begin
        if (c_a && c_b)        c_in = 1'b1;
        else if (!c_a && !c_b) c_in = 1'b0;
      end
    endcase
  end

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int j = 0; j < N; j++)
      if (r[(p + j) % N]) return (p + j) % N;
    return -1;
  endfunction

  // offset of the last busy cycle of a transaction for a given C-element behaviour
  function automatic int last_busy(input int md);
    if (md == 0) return 2 * K + 2 * (S + 1) + 3 - 1;
    if (md == 1) return K + S + 2;
`ifdef MULLER_C_TIMEOUT_EN
    return K + T + 1;
`else
    return 1 << 30;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mk <= 0; mwin <= 0; mptr <= 0; mmode <= 0; merr <= 1'b0;
    end else begin
      merr <= 1'b0;
      if (mk == 0) begin
        if (req != '0) mk <= 1;
      end else if (mk == 1) begin
        if (pick(req, mptr) < 0) mk <= 0;
        else begin
          mwin  <= pick(req, mptr);
          mmode <= int'(mode);
          mk    <= 2;
        end
      end else if (mk == last_busy(mmode)) begin
        mk    <= 0;
        mptr  <= (mwin + 1) % N;
        merr  <= (mmode == 2);
      end else begin
        mk <= mk + 1;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // one cycle: step to the falling edge and compare every output against the model
  task automatic tick();
    int           lb;
    logic [N-1:0] oh;
    logic [N-1:0] eg;
    logic [N-1:0] ed;
    logic         ea, eb, ee, ebz;
    @(negedge clk);
    lb  = last_busy(mmode);
    oh  = '0;
    oh[mwin] = 1'b1;
    ebz = (mk != 0);
    eg  = (mk >= 2) ? oh : '0;
    ea  = (mk >= 2) && (mk <= ((mmode == 0) ? K + S + 2 : (mmode == 1) ? K + 1 : lb));
    eb  = (mmode != 1) && (mk >= K + 2) && (mk <= ((mmode == 0) ? 2 * K + S + 2 : lb));
    ed  = (mmode == 0 && mk >= 2 && mk == lb) ? oh : '0;
    ee  = merr || (mmode == 1 && mk == K + 2);
    check("m_gnt", gnt, eg);
    check("m_done", done, ed);
    check("m_err", err, ee);
    check("m_busy", busy, ebz);
    check("m_c_a", c_a, ea);
    check("m_c_b", c_b, eb);
    if (|done) done_cnt++;
  endtask

  task automatic wait_for(input int which, input int bound, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      tick();
      case (which)
        0:       hit = (gnt != '0);
        1:       hit = (done != '0);
        2:       hit = err;
        3:       hit = !busy;
        4:       hit = c_b;
        5:       hit = c_a;
        default: hit = (gnt == '0);
      endcase
    end
    check({nm, "_seen"}, 32'(hit), 32'd1);
  endtask

  initial begin
    int           c0;
    int           t1;
    int           g [3];
    logic [N-1:0] exp_seq [4];

    mode  = 2'd0;
    req   = 4'b1111;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // reset with all requests pending
    tick();
    tick();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_c_a", c_a, 0);
    check("rst_c_b", c_b, 0);
    rst_n = 1'b1;
    c0    = cyc;
    wait_for(0, 10, "t1_gnt");
    check("t1_latency", cyc - c0, 2);
    check("t1_gnt", gnt, 4'b0001);
    req = '0;
    wait_for(1, 30, "t1_done");
    check("t1_done", done, 4'b0001);
    wait_for(3, 5, "t1_idle");

    // ideal C-element, two requesters, two transactions each
    exp_seq = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    req = 4'b1010;
    wait_for(5, 10, "t2_c_a");
    t1 = cyc;
    wait_for(4, 10, "t2_c_b");
    check("t2_skew", cyc - t1, 4);
    for (int i = 0; i < 4; i++) begin
      wait_for(1, 30, "t2_done");
      check("t2_order_gnt", gnt, exp_seq[i]);
      check("t2_order_done", done, exp_seq[i]);
    end
    req = '0;
    wait_for(3, 5, "t2_idle");

    // faulty C-element: c follows a alone
    mode = 2'd1;
    req  = 4'b0011;
    c0   = done_cnt;
    wait_for(2, 20, "t3_err");
    check("t3_err_gnt", gnt, 4'b0001);
    check("t3_err_c_a", c_a, 0);
    check("t3_err_c_b", c_b, 0);
    wait_for(3, 10, "t3_idle");
    check("t3_no_done", done_cnt - c0, 0);
    mode = 2'd0;
    wait_for(0, 5, "t3_next");
    check("t3_next_gnt", gnt, 4'b0010);
    req = '0;
    wait_for(1, 30, "t3_done");
    check("t3_done", done, 4'b0010);
    wait_for(3, 5, "t3_idle2");

    // stuck-at-0 C-element
    mode = 2'd2;
    req  = 4'b0100;
    wait_for(4, 15, "t4_c_b");
    t1 = cyc;
`ifdef MULLER_C_TIMEOUT_EN
    c0 = done_cnt;
    wait_for(2, 100, "t4_timeout");
    check("t4_to_cycles", cyc - t1, 64);
    check("t4_to_busy", busy, 0);
    check("t4_to_gnt", gnt, 0);
    check("t4_to_no_done", done_cnt - c0, 0);
    wait_for(4, 15, "t4_regrant_c_b");
    check("t4_regrant", gnt, 4'b0100);
`else
    for (int i = 0; i < 80; i++) tick();
    check("t4_hang_busy", busy, 1);
    check("t4_hang_gnt", gnt, 4'b0100);
`endif

    // asynchronous reset while waiting for c to rise
    @(posedge clk);
    #3;
    check("t5_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_c_a", c_a, 0);
    check("t5_c_b", c_b, 0);
    check("t5_gnt", gnt, 0);
    check("t5_busy", busy, 0);
    req  = '0;
    mode = 2'd0;
    tick();
    tick();
    rst_n = 1'b1;

    // single requester 3, back-to-back, pointer wraps
    req = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      wait_for(0, 25, "t6_gnt");
      g[i] = cyc;
      check("t6_gnt", gnt, 4'b1000);
      if (i < 2) wait_for(6, 25, "t6_release");
    end
    check("t6_period1", g[1] - g[0], 17);
    check("t6_period2", g[2] - g[1], 17);
    req = '0;
    wait_for(1, 30, "t6_done");
    check("t6_done", done, 4'b1000);
    wait_for(3, 5, "t6_idle");
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
